// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial MUL (shift-add) / DIV (restoring) sequencer, one bit per clock.
// Define MULDIV_SIGNED_EN to add the sgn port and a FIXUP state for two's complement operands.
module muldiv_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             dz
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, FIXUP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_a, r_b;
  logic               r_op;
  logic [WIDTH:0]     w_sum, w_rem_sh;
  logic [WIDTH-1:0]   w_diff, w_ma, w_mb;
  logic               w_ge, w_last;
  logic [2*WIDTH-1:0] w_next;
`ifdef MULDIV_SIGNED_EN
  logic               r_sgn, r_sa, r_neg;
  logic [2*WIDTH-1:0] w_fix;
  assign w_ma = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_mb = (sgn && b[WIDTH-1]) ? -b : b;
  // Product negated as a whole; quotient follows sign mismatch, remainder follows the dividend.
  assign w_fix = r_op ? {r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH],
                         r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]}
                      : (r_neg ? -r_acc : r_acc);
`else
  assign w_ma = a;
  assign w_mb = b;
`endif
  // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge     = w_rem_sh >= {1'b0, r_b};
    w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
    w_next   = r_op ? {w_ge ? w_diff : w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], w_ge}
                    : {w_sum, r_acc[WIDTH-1:1]};
    w_last   = r_cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      dz        <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_sgn     <= 1'b0;
      r_sa      <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_op  <= op;
          r_a   <= w_ma;
          r_b   <= w_mb;
          r_cnt <= '0;
          r_acc <= op ? {{WIDTH{1'b0}}, w_ma} : {{WIDTH{1'b0}}, w_mb};
          dz    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
          r_sgn <= sgn;
          r_sa  <= sgn & a[WIDTH-1];
          r_neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
          if (op && b == '0) begin
            r_state   <= DONE;
            done      <= 1'b1;
            result_lo <= '1;
            result_hi <= a;
            dz        <= 1'b1;
          end else begin
            r_state <= RUN;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + 1'b1;
`ifdef MULDIV_SIGNED_EN
          if (w_last && r_sgn) begin
            busy    <= 1'b0;
            r_state <= FIXUP;
          end else
`endif
          if (w_last) begin
            busy                   <= 1'b0;
            r_state                <= DONE;
            done                   <= 1'b1;
            {result_hi, result_lo} <= w_next;
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIXUP: begin
          r_state                <= DONE;
          done                   <= 1'b1;
          {result_hi, result_lo} <= w_fix;
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results for muldiv_sequencer.
module tb_muldiv_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, op = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, dz;
  logic [7:0] result_lo, result_hi;
`ifdef MULDIV_SIGNED_EN
  logic sgn = 1'b0;
`endif
  int n_chk = 0, n_err = 0, n_done = 0, lat = 0, busy_cyc = 0, d0 = 0;

  muldiv_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
`ifdef MULDIV_SIGNED_EN
    .sgn(sgn),
`endif
    .a(a), .b(b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .dz(dz)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one instruction, scrambles operands after the start edge, waits for done.
  task automatic run(input logic o, input logic [7:0] x, input logic [7:0] y, input logic s);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
`ifdef MULDIV_SIGNED_EN
    sgn = s;
`endif
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = ~x; b = ~y;
`ifdef MULDIV_SIGNED_EN
    sgn = ~s;
`endif
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      busy_cyc += int'(busy);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic res(input string tag, input logic [15:0] r, input logic z, input int l);
    chk({tag, "_lat"}, lat, l);
    chk({tag, "_res"}, {16'd0, result_hi, result_lo}, {16'd0, r});
    chk({tag, "_dz"}, {31'd0, dz}, {31'd0, z});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {16'd0, result_hi, result_lo}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run(1'b0, 8'hFF, 8'hFF, 1'b0); res("mul_ff_ff", 16'hFE01, 1'b0, 9);
    chk("mul_ff_busy", busy_cyc, 8);
    run(1'b1, 8'd200, 8'd7, 1'b0);  res("div_200_7", 16'h041C, 1'b0, 9);
    run(1'b0, 8'h00, 8'h5A, 1'b0);  res("mul_zero", 16'h0000, 1'b0, 9);
    run(1'b0, 8'h80, 8'h02, 1'b0);  res("mul_80_2", 16'h0100, 1'b0, 9);
    run(1'b1, 8'hFF, 8'h01, 1'b0);  res("div_ff_1", 16'h00FF, 1'b0, 9);
    run(1'b1, 8'd5, 8'd9, 1'b0);    res("div_5_9", 16'h0500, 1'b0, 9);
    run(1'b1, 8'h55, 8'h00, 1'b0);  res("div_zero", 16'h55FF, 1'b1, 1);
    repeat (3) @(negedge clk);
    chk("dz_hold", {31'd0, dz}, 32'd1);
    run(1'b0, 8'd2, 8'd3, 1'b0);    res("dz_clear", 16'h0006, 1'b0, 9);

    // starts during RUN and during the done cycle must be dropped
    @(negedge clk);
    d0 = n_done;
    start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd4;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd3;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && !done; k++) @(negedge clk);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_res", {16'd0, result_hi, result_lo}, 32'h000C);
    start = 1'b1; op = 1'b1; a = 8'd9; b = 8'd3;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("ign_pulses", n_done - d0, 1);
    chk("ign_busy", {31'd0, busy}, 32'd0);

    // asynchronous reset in the middle of a multiply
    @(negedge clk);
    d0 = n_done;
    start = 1'b1; op = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_res", {16'd0, result_hi, result_lo}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_no_pulse", n_done - d0, 0);
    reset = 1'b1;
    run(1'b0, 8'h12, 8'h34, 1'b0);  res("mid_rerun", 16'h03A8, 1'b0, 9);

`ifdef MULDIV_SIGNED_EN
    run(1'b0, 8'hFA, 8'h07, 1'b1);  res("smul", 16'hFFD6, 1'b0, 10);
    run(1'b1, 8'hF9, 8'h02, 1'b1);  res("sdiv", 16'hFFFD, 1'b0, 10);
    run(1'b1, 8'h80, 8'hFF, 1'b1);  res("sdiv_ovf", 16'h0080, 1'b0, 10);
    run(1'b0, 8'hFA, 8'h07, 1'b0);  res("sgn0_mul", 16'h06D6, 1'b0, 9);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
